// File: rtl/dma_arbiter.sv
// dma_arbiter: shares the single dma_access memory-DMA channel between N
// requesters (0 = ZX DMA, 1 = SD DMA, 2 = MP3 DMA) with round-robin grant.
//
// Ports:
//   clk, rst            system clock, asynchronous active-high reset
//   req[N]              per-requester request, held until its req_ack
//   req_addr[N*AW]      per-requester address, slice i at [i*AW +: AW]
//   req_rnw[N]          per-requester direction (1 = read)
//   req_wd[N*DW]        per-requester write data
//   req_ack[N]          one-hot: access of requester i accepted
//   req_end[N]          one-hot: access of requester i completed, req_rd valid
//   req_rd[DW]          read data broadcast (= dma_rd)
//   dma_req/addr/rnw/wd request side towards dma_access
//   dma_ack, dma_end    accept / completion pulses from dma_access
//   dma_rd[DW]          read data from dma_access, valid with dma_end
module dma_arbiter #(
  parameter int N  = 3,
  parameter int AW = 21,
  parameter int DW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic [N*AW-1:0] req_addr,
  input  logic [N-1:0]    req_rnw,
  input  logic [N*DW-1:0] req_wd,
  output logic [N-1:0]    req_ack,
  output logic [N-1:0]    req_end,
  output logic [DW-1:0]   req_rd,
  output logic            dma_req,
  output logic [AW-1:0]   dma_addr,
  output logic            dma_rnw,
  output logic [DW-1:0]   dma_wd,
  input  logic            dma_ack,
  input  logic            dma_end,
  input  logic [DW-1:0]   dma_rd
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic          grant_valid;
  logic [IW-1:0] grant_idx;
  logic [IW-1:0] rr_ptr;
  // Owner tags of accepted-but-unfinished accesses; tag0 is the head.
  logic [IW-1:0] tag0, tag1;
  logic [1:0]    count;

  logic push, pop, fifo_full;

  // Wraps at N so a non-power-of-two N never yields an index >= N.
  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
    next_idx = (int'(i) >= N - 1) ? '0 : i + IW'(1);
  endfunction

  function automatic logic [IW-1:0] rr_pick(input logic [N-1:0] r,
                                            input logic [IW-1:0] ptr);
    logic [IW-1:0] idx;
    logic          found;
    rr_pick = ptr;
    idx     = ptr;
    found   = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!found && r[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
      idx = next_idx(idx);
    end
  endfunction

  assign fifo_full = (count == 2'd2);
  assign push      = dma_ack & grant_valid;
  assign pop       = dma_end & (count != 2'd0);
  assign req_rd    = dma_rd;

  always_comb begin
    dma_req  = 1'b0;
    dma_addr = '0;
    dma_rnw  = 1'b1;
    dma_wd   = '0;
    req_ack  = '0;
    req_end  = '0;
    if (grant_valid) begin
      // A grant may exist while the tag FIFO is full; hold the request off.
      dma_req  = req[grant_idx] & ~fifo_full;
      dma_addr = req_addr[int'(grant_idx)*AW +: AW];
      dma_rnw  = req_rnw[grant_idx];
      dma_wd   = req_wd[int'(grant_idx)*DW +: DW];
    end
    if (push) req_ack[grant_idx] = 1'b1;
    if (pop)  req_end[tag0]      = 1'b1;
  end

  // Grant register and round-robin pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_valid <= 1'b0;
      grant_idx   <= '0;
      rr_ptr      <= '0;
    end else if (push) begin
      grant_valid <= 1'b0;
      rr_ptr      <= next_idx(grant_idx);
    end else if (grant_valid && !req[grant_idx]) begin
      // Requester withdrew before ack: drop the grant, keep rr_ptr.
      grant_valid <= 1'b0;
    end else if (!grant_valid && !fifo_full && (|req)) begin
      grant_valid <= 1'b1;
      grant_idx   <= rr_pick(req, rr_ptr);
    end
  end

  // Owner tag FIFO (depth 2, shift towards head on pop)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag0  <= '0;
      tag1  <= '0;
      count <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) tag0 <= grant_idx;
          else               tag1 <= grant_idx;
          count <= count + 2'd1;
        end
        2'b01: begin
          tag0  <= tag1;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            tag0 <= grant_idx;
          end else begin
            tag0 <= tag1;
            tag1 <= grant_idx;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_arbiter.sv
// Testbench for dma_arbiter: per-cycle vector table plus hand-written
// sequences for request withdrawal, asynchronous reset mid-access and
// simultaneous accept/complete.
module tb_dma_arbiter;

  localparam int N  = 3;
  localparam int AW = 21;
  localparam int DW = 8;

  localparam logic [AW-1:0] A0 = 21'h00111;
  localparam logic [AW-1:0] A1 = 21'h1ABCD;
  localparam logic [AW-1:0] A2 = 21'h1F222;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req = '0;
  logic [N*AW-1:0] req_addr;
  logic [N-1:0]    req_rnw;
  logic [N*DW-1:0] req_wd;
  logic [N-1:0]    req_ack, req_end;
  logic [DW-1:0]   req_rd;
  logic            dma_req;
  logic [AW-1:0]   dma_addr;
  logic            dma_rnw;
  logic [DW-1:0]   dma_wd;
  logic            dma_ack = 1'b0;
  logic            dma_end = 1'b0;
  logic [DW-1:0]   dma_rd  = '0;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign req_addr = {A2, A1, A0};
  assign req_rnw  = 3'b110;
  assign req_wd   = {8'h33, 8'h22, 8'h11};

  dma_arbiter #(.N(N), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .req(req), .req_addr(req_addr), .req_rnw(req_rnw), .req_wd(req_wd),
    .req_ack(req_ack), .req_end(req_end), .req_rd(req_rd),
    .dma_req(dma_req), .dma_addr(dma_addr), .dma_rnw(dma_rnw), .dma_wd(dma_wd),
    .dma_ack(dma_ack), .dma_end(dma_end), .dma_rd(dma_rd)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic          rst;
    logic [N-1:0]  req;
    logic          ack;
    logic          dend;
    logic [DW-1:0] rd;
    logic          e_dreq;
    logic [AW-1:0] e_addr;
    logic          e_rnw;
    logic [N-1:0]  e_ack;
    logic [N-1:0]  e_end;
  } vec_t;

  function automatic vec_t v(input logic r, input logic [N-1:0] q, input logic a,
                             input logic e, input logic [DW-1:0] d, input logic xq,
                             input logic [AW-1:0] xa, input logic xr,
                             input logic [N-1:0] xk, input logic [N-1:0] xe);
    v = '{r, q, a, e, d, xq, xa, xr, xk, xe};
  endfunction

  vec_t tbl[32];

  initial begin
    // rst req   ack end rd     dreq addr rnw ack     end
    tbl[0]  = v(1, 3'b000, 0, 0, 8'h00, 0, '0, 1, 3'b000, 3'b000);
    // single requester 1
    tbl[1]  = v(0, 3'b010, 0, 0, 8'h00, 0, '0, 1, 3'b000, 3'b000);
    tbl[2]  = v(0, 3'b010, 0, 0, 8'h00, 1, A1, 1, 3'b000, 3'b000);
    tbl[3]  = v(0, 3'b010, 1, 0, 8'h00, 1, A1, 1, 3'b010, 3'b000);
    tbl[4]  = v(0, 3'b000, 0, 1, 8'h5A, 0, '0, 1, 3'b000, 3'b010);
    // round robin 0,1,2,0 with ack two cycles after dma_req
    tbl[5]  = v(1, 3'b000, 0, 0, 8'h00, 0, '0, 1, 3'b000, 3'b000);
    tbl[6]  = v(0, 3'b111, 0, 0, 8'h00, 0, '0, 1, 3'b000, 3'b000);
    tbl[7]  = v(0, 3'b111, 0, 0, 8'h00, 1, A0, 0, 3'b000, 3'b000);
    tbl[8]  = v(0, 3'b111, 0, 0, 8'h00, 1, A0, 0, 3'b000, 3'b000);
    tbl[9]  = v(0, 3'b111, 1, 0, 8'h00, 1, A0, 0, 3'b001, 3'b000);
    tbl[10] = v(0, 3'b111, 0, 1, 8'h11, 0, '0, 1, 3'b000, 3'b001);
    tbl[11] = v(0, 3'b111, 0, 0, 8'h00, 1, A1, 1, 3'b000, 3'b000);
    tbl[12] = v(0, 3'b111, 0, 0, 8'h00, 1, A1, 1, 3'b000, 3'b000);
    tbl[13] = v(0, 3'b111, 1, 0, 8'h00, 1, A1, 1, 3'b010, 3'b000);
    tbl[14] = v(0, 3'b111, 0, 1, 8'h22, 0, '0, 1, 3'b000, 3'b010);
    tbl[15] = v(0, 3'b111, 0, 0, 8'h00, 1, A2, 1, 3'b000, 3'b000);
    tbl[16] = v(0, 3'b111, 0, 0, 8'h00, 1, A2, 1, 3'b000, 3'b000);
    tbl[17] = v(0, 3'b111, 1, 0, 8'h00, 1, A2, 1, 3'b100, 3'b000);
    tbl[18] = v(0, 3'b111, 0, 1, 8'h33, 0, '0, 1, 3'b000, 3'b100);
    tbl[19] = v(0, 3'b111, 0, 0, 8'h00, 1, A0, 0, 3'b000, 3'b000);
    // pipelined: ack 0 then 2, FIFO full holds the third request off
    tbl[20] = v(0, 3'b111, 1, 0, 8'h00, 1, A0, 0, 3'b001, 3'b000);
    tbl[21] = v(0, 3'b101, 0, 0, 8'h00, 0, '0, 1, 3'b000, 3'b000);
    tbl[22] = v(0, 3'b101, 1, 0, 8'h00, 1, A2, 1, 3'b100, 3'b000);
    tbl[23] = v(0, 3'b101, 0, 0, 8'h00, 0, '0, 1, 3'b000, 3'b000);
    tbl[24] = v(0, 3'b101, 0, 0, 8'h00, 0, '0, 1, 3'b000, 3'b000);
    tbl[25] = v(0, 3'b101, 0, 1, 8'hA1, 0, '0, 1, 3'b000, 3'b001);
    tbl[26] = v(0, 3'b101, 0, 0, 8'h00, 0, '0, 1, 3'b000, 3'b000);
    tbl[27] = v(0, 3'b101, 0, 0, 8'h00, 1, A0, 0, 3'b000, 3'b000);
    // ack 0 and end of 2 together, then drain and spurious ends
    tbl[28] = v(0, 3'b101, 1, 1, 8'hB2, 1, A0, 0, 3'b001, 3'b100);
    tbl[29] = v(0, 3'b000, 0, 1, 8'hC3, 0, '0, 1, 3'b000, 3'b001);
    tbl[30] = v(0, 3'b000, 0, 1, 8'hD4, 0, '0, 1, 3'b000, 3'b000);
    tbl[31] = v(0, 3'b000, 0, 1, 8'h00, 0, '0, 1, 3'b000, 3'b000);

    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      rst = tbl[i].rst; req = tbl[i].req; dma_ack = tbl[i].ack;
      dma_end = tbl[i].dend; dma_rd = tbl[i].rd;
      #1;
      check($sformatf("v%0d_dma_req", i),  32'(dma_req),  32'(tbl[i].e_dreq));
      check($sformatf("v%0d_dma_addr", i), 32'(dma_addr), 32'(tbl[i].e_addr));
      check($sformatf("v%0d_dma_rnw", i),  32'(dma_rnw),  32'(tbl[i].e_rnw));
      check($sformatf("v%0d_req_ack", i),  32'(req_ack),  32'(tbl[i].e_ack));
      check($sformatf("v%0d_req_end", i),  32'(req_end),  32'(tbl[i].e_end));
      check($sformatf("v%0d_req_rd", i),   32'(req_rd),   32'(tbl[i].rd));
    end

    // Withdrawal before ack
    @(negedge clk);
    dma_end = 0; dma_ack = 0; req = 3'b000;
    rst = 1; #1 rst = 0;
    req = 3'b001;
    @(negedge clk); #1;
    check("wd_granted", 32'(dma_req), 32'd1);
    req = 3'b000; #1;
    check("wd_drop_same_cycle", 32'(dma_req), 32'd0);
    @(negedge clk);
    dma_end = 1; #1;
    check("wd_no_tag_end", 32'(req_end), 32'd0);
    check("wd_dreq_low", 32'(dma_req), 32'd0);
    dma_end = 0; req = 3'b010;
    @(negedge clk); #1;
    check("wd_next_grant_req", 32'(dma_req), 32'd1);
    check("wd_next_grant_addr", 32'(dma_addr), 32'(A1));

    // Asynchronous reset with grant_valid=1, count=1
    dma_ack = 1; #1;
    check("rs_ack1", 32'(req_ack), 32'b010);
    @(negedge clk);
    dma_ack = 0; req = 3'b100;
    @(negedge clk); #1;
    check("rs_grant2_req", 32'(dma_req), 32'd1);
    check("rs_grant2_wd", 32'(dma_wd), 32'h33);
    #2 rst = 1; #1;
    check("rs_dma_req", 32'(dma_req), 32'd0);
    check("rs_dma_addr", 32'(dma_addr), 32'd0);
    check("rs_dma_rnw", 32'(dma_rnw), 32'd1);
    check("rs_dma_wd", 32'(dma_wd), 32'd0);
    dma_ack = 1; dma_end = 1; #1;
    check("rs_req_ack", 32'(req_ack), 32'd0);
    check("rs_req_end", 32'(req_end), 32'd0);
    dma_ack = 0; dma_end = 0;
    @(negedge clk);
    rst = 0;
    @(negedge clk); #1;
    check("rs_after_req", 32'(dma_req), 32'd1);
    check("rs_after_addr", 32'(dma_addr), 32'(A2));
    dma_end = 1; #1;
    check("rs_fifo_cleared", 32'(req_end), 32'd0);
    dma_end = 0;

    // Simultaneous ack and end with head=1, granted=2
    @(negedge clk);
    req = 3'b000;
    rst = 1; #1 rst = 0;
    req = 3'b010;
    @(negedge clk);
    dma_ack = 1; #1;
    check("sm_ack1", 32'(req_ack), 32'b010);
    @(negedge clk);
    dma_ack = 0; req = 3'b100;
    @(negedge clk);
    dma_ack = 1; dma_end = 1; dma_rd = 8'h77; #1;
    check("sm_ack2", 32'(req_ack), 32'b100);
    check("sm_end1", 32'(req_end), 32'b010);
    check("sm_rd", 32'(req_rd), 32'h77);
    @(negedge clk);
    dma_ack = 0; dma_end = 1; req = 3'b000; dma_rd = 8'h88; #1;
    check("sm_end2", 32'(req_end), 32'b100);
    @(negedge clk); #1;
    check("sm_empty", 32'(req_end), 32'd0);
    dma_end = 0;

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/dma_arbiter.md
Name: dma_arbiter

Overview:
- Shares the single dma_access memory-DMA channel between up to N DMA requesters (ZX-bus DMA, SD-card DMA, MP3 DMA).
- Round-robin grant, one access at a time presented to dma_access.
- Routes dma_ack to the granted requester and dma_end to the owner of the completing access.
- Sits between the requester modules and dma_access in main; dma_access's request-side ports connect here instead of directly to dma_zx.

Parameters:
- N, 3, number of requesters (index 0 = ZX DMA, 1 = SD DMA, 2 = MP3 DMA).
- AW, 21, DMA address width (2 MB space: ram chip select from [20:19]).
- DW, 8, data width.

Ports:
- clk  in  1  system clock (clk_fpga domain).
- rst  in  1  asynchronous reset, active-high.
- req  in  N  per-requester access request; held until that requester's ack.
- req_addr  in  N*AW  per-requester address; requester i uses bits [i*AW +: AW]; stable while req[i] high.
- req_rnw  in  N  per-requester direction: 1 = read, 0 = write.
- req_wd  in  N*DW  per-requester write data.
- req_ack  out  N  one-hot pulse: access of requester i accepted.
- req_end  out  N  one-hot pulse: access of requester i completed; read data valid on req_rd this cycle.
- req_rd  out  DW  read data broadcast to all requesters (= dma_rd).
- dma_req  out  1  request to dma_access.
- dma_addr  out  AW  address to dma_access.
- dma_rnw  out  1  direction to dma_access.
- dma_wd  out  DW  write data to dma_access.
- dma_ack  in  1  dma_access accepted current request (1-cycle pulse).
- dma_end  in  1  dma_access finished oldest outstanding access (1-cycle pulse).
- dma_rd  in  DW  read data from dma_access, valid with dma_end.

Behaviour:
- State: grant_valid (1b), grant_idx (log2 N), rr_ptr (log2 N), 2-entry owner tag FIFO (idx + count 0..2).
- Reset (asynchronous, while rst=1): grant_valid=0, grant_idx=0, rr_ptr=0, FIFO empty, count=0.
- Reset output values: dma_req=0, dma_addr=0, dma_rnw=1, dma_wd=0, req_ack=0, req_end=0. req_rd follows dma_rd.
- dma_req/addr/rnw/wd: combinational mux of the granted requester's signals. dma_req = grant_valid & req[grant_idx]. When grant_valid=0: addr=0, rnw=1, wd=0.
- Arbitration (registered):
  - Arbitration runs when grant_valid=0, count<2 and |req.
  - Next cycle: grant_valid=1, grant_idx = first requester with req=1 searching rr_ptr, rr_ptr+1, … modulo N.
  - Latency: req rising in an idle arbiter gives dma_req high exactly 1 cycle later.
- Accept:
  - req_ack = dma_ack & grant_valid, one-hot at grant_idx (combinational, same cycle).
  - On that cycle: push grant_idx to FIFO, clear grant_valid, rr_ptr = grant_idx+1 mod N.
  - Back-to-back grants therefore have exactly one cycle of dma_req=0 between them.
- Completion:
  - req_end = dma_end & (count>0), one-hot at the FIFO head (combinational). Pop head on the same cycle.
  - dma_end with count=0 is ignored: no req_end, count stays 0.
- Simultaneous dma_ack and dma_end: pop the head and push the new tag in the same cycle. Count is unchanged; req_end goes to the old head.
- FIFO full (count=2): no new grant until a pop. An existing grant stays, but dma_req is forced 0 until count<2. dma_ack while count=2 cannot occur.
- Requester drops req[grant_idx] before ack (protocol violation): dma_req falls immediately. The next cycle clears grant_valid without a push, and rr_ptr is unchanged.
- Requests from non-granted requesters never disturb the current grant; no preemption.
- N not a power of two: rr_ptr and the search wrap at N, never index ≥N.

Test Plan:
- Single requester: req[1]=1, addr=0x1ABCD, rnw=1. Expect dma_req=1 at cycle+1 with dma_addr=0x1ABCD. dma_ack gives req_ack=3'b010. dma_end with dma_rd=0x5A gives req_end=3'b010, req_rd=0x5A.
- Round-robin: req=3'b111 held, ack each grant 2 cycles after dma_req. Expect grant order 0,1,2,0,1,2 and one idle dma_req cycle between grants.
- Pipelined ends: ack requester 0, then ack requester 2 before any end. The third pending request keeps dma_req=0 (count=2). dma_end twice gives req_end 3'b001 then 3'b100, and dma_req reasserts after the first end.
- Simultaneous dma_ack and dma_end with count=1 (head=1, granted=2): req_ack=3'b100 and req_end=3'b010 in the same cycle, count stays 1, next end goes to requester 2.
- Spurious dma_end with FIFO empty: req_end stays 0, count stays 0. Requester withdraws req before ack: dma_req drops the same cycle, no tag pushed.
- rst pulsed mid-access (grant_valid=1, count=1): all outputs return to reset values asynchronously. After release, a pending req[2] is granted first with rr_ptr=0 search order.
